// File: rtl/jt900h_memarb.sv
// Two-port arbiter/sequencer sharing one 16-bit synchronous RAM between the jt900h CPU bus
// and an auxiliary requester. One access at a time, registered outputs, cen-qualified state.
module jt900h_memarb #(
  parameter int AW      = 12,
  parameter int RDLAT   = 1,
  parameter int MAXWAIT = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,

  input  logic          cpu_req,
  input  logic [23:0]   cpu_addr,
  input  logic [15:0]   cpu_din,
  input  logic [1:0]    cpu_we,
  output logic [15:0]   cpu_dout,
  output logic          cpu_rdy,

  input  logic          aux_req,
  input  logic [23:0]   aux_addr,
  input  logic [15:0]   aux_din,
  input  logic [1:0]    aux_we,
  output logic [15:0]   aux_dout,
  output logic          aux_rdy,

  output logic          mem_cs,
  output logic [AW-2:0] mem_addr,
  output logic [15:0]   mem_din,
  output logic [1:0]    mem_we,
  input  logic [15:0]   mem_dout,
  output logic          gnt
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [2:0] LAT_M1 = 3'(RDLAT - 1);
  localparam logic [7:0] MAXW   = 8'(MAXWAIT);

  state_t        state, state_nxt;
  logic [2:0]    cnt, cnt_nxt;
  logic          rd, rd_nxt;
  logic [7:0]    starve, starve_nxt;
  logic          pick_aux;

  logic          mem_cs_nxt, gnt_nxt, cpu_rdy_nxt, aux_rdy_nxt;
  logic [AW-2:0] mem_addr_nxt;
  logic [15:0]   mem_din_nxt, cpu_dout_nxt, aux_dout_nxt;
  logic [1:0]    mem_we_nxt;

  // Byte-select bit and the bits above the RAM window are aliased away.
  logic unused_ok;
  assign unused_ok = &{1'b0, cpu_addr[23:AW], cpu_addr[0], aux_addr[23:AW], aux_addr[0]};

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_nxt    = state;
    cnt_nxt      = cnt;
    rd_nxt       = rd;
    starve_nxt   = starve;
    pick_aux     = 1'b0;
    mem_cs_nxt   = mem_cs;
    mem_addr_nxt = mem_addr;
    mem_din_nxt  = mem_din;
    mem_we_nxt   = mem_we;
    gnt_nxt      = gnt;
    cpu_rdy_nxt  = cpu_rdy;
    aux_rdy_nxt  = aux_rdy;
    cpu_dout_nxt = cpu_dout;
    aux_dout_nxt = aux_dout;

    case (state)
      IDLE: begin
        if (cpu_req || aux_req) begin
          // CPU has priority until aux has waited MAXWAIT CPU grants.
          pick_aux   = aux_req && (!cpu_req || starve >= MAXW);
          state_nxt  = ACCESS;
          mem_cs_nxt = 1'b1;
          gnt_nxt    = pick_aux;
          cnt_nxt    = LAT_M1;
          if (pick_aux) begin
            mem_addr_nxt = aux_addr[AW-1:1];
            mem_din_nxt  = aux_din;
            mem_we_nxt   = aux_we;
            rd_nxt       = (aux_we == 2'b00);
            starve_nxt   = 8'd0;
          end else begin
            mem_addr_nxt = cpu_addr[AW-1:1];
            mem_din_nxt  = cpu_din;
            mem_we_nxt   = cpu_we;
            rd_nxt       = (cpu_we == 2'b00);
            if (aux_req && starve < MAXW) starve_nxt = starve + 8'd1;
          end
        end
      end

      ACCESS: begin
        mem_we_nxt = 2'b00;
        if (!rd || cnt == 3'd0) begin
          state_nxt  = DONE;
          mem_cs_nxt = 1'b0;
          if (gnt) begin
            aux_rdy_nxt = 1'b1;
            if (rd) aux_dout_nxt = mem_dout;
          end else begin
            cpu_rdy_nxt = 1'b1;
            if (rd) cpu_dout_nxt = mem_dout;
          end
        end else begin
          cnt_nxt = cnt - 3'd1;
        end
      end

      DONE: begin
        cpu_rdy_nxt = 1'b0;
        aux_rdy_nxt = 1'b0;
        state_nxt   = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else if (cen) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= 3'd0;
      rd       <= 1'b0;
      starve   <= 8'd0;
      mem_cs   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= 16'd0;
      mem_we   <= 2'b00;
      gnt      <= 1'b0;
      cpu_rdy  <= 1'b0;
      aux_rdy  <= 1'b0;
      cpu_dout <= 16'd0;
      aux_dout <= 16'd0;
    end else if (cen) begin
      cnt      <= cnt_nxt;
      rd       <= rd_nxt;
      starve   <= starve_nxt;
      mem_cs   <= mem_cs_nxt;
      mem_addr <= mem_addr_nxt;
      mem_din  <= mem_din_nxt;
      mem_we   <= mem_we_nxt;
      gnt      <= gnt_nxt;
      cpu_rdy  <= cpu_rdy_nxt;
      aux_rdy  <= aux_rdy_nxt;
      cpu_dout <= cpu_dout_nxt;
      aux_dout <= aux_dout_nxt;
    end
  end

endmodule
